// File: rtl/urv_div_sequencer.sv
// rtl/urv_div_sequencer.sv - multi-cycle RV32M DIV/DIVU/REM/REMU sequencer for Execute
// Restoring shift-subtract divider; holds the pipeline until the result is registered.
module urv_div_sequencer #(
  parameter int XLEN            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            x_stall_i,
  input  logic            x_kill_i,
  input  logic            x_start_i,
  input  logic [2:0]      x_fun_i,
  input  logic [XLEN-1:0] x_rs1_value_i,
  input  logic [XLEN-1:0] x_rs2_value_i,
  output logic            x_stall_req_o,
  output logic            x_div_done_o,
  output logic [XLEN-1:0] x_div_result_o
);

  localparam int ITERS = XLEN / STEPS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS) + 1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t            state;
  logic [2:0]        fun;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [XLEN-1:0]   dvd;
  logic [XLEN-1:0]   dsr;
  logic [XLEN-1:0]   rem;
  logic [CNT_W-1:0]  cnt;
  logic              sign_q;
  logic              sign_r;

  logic              signed_op;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN-1:0]   step_dvd;
  logic [XLEN-1:0]   step_rem;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   fix_q;
  logic [XLEN-1:0]   fix_r;

  // All legal divide encodings have fun[2] set; fun[0]=0 selects the signed variants.
  assign signed_op = fun[2] & ~fun[0];
  assign abs_a     = (signed_op && op_a[XLEN-1]) ? -op_a : op_a;
  assign abs_b     = (signed_op && op_b[XLEN-1]) ? -op_b : op_b;
  assign fix_q     = sign_q ? -dvd : dvd;
  assign fix_r     = sign_r ? -rem : rem;

  // The dividend register shifts left and collects quotient bits in its LSBs.
  always_comb begin
    step_dvd = dvd;
    step_rem = rem;
    trial    = '0;
    for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
      trial    = {step_rem, step_dvd[XLEN-1]};
      step_dvd = {step_dvd[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, dsr}) begin
        trial       = trial - {1'b0, dsr};
        step_dvd[0] = 1'b1;
      end
      step_rem = trial[XLEN-1:0];
    end
  end

  assign x_stall_req_o = !x_kill_i &&
                         ((state == IDLE && x_start_i) || state == PREP ||
                          state == ITER || state == FIX);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      fun            <= '0;
      op_a           <= '0;
      op_b           <= '0;
      dvd            <= '0;
      dsr            <= '0;
      rem            <= '0;
      cnt            <= '0;
      sign_q         <= 1'b0;
      sign_r         <= 1'b0;
      x_div_done_o   <= 1'b0;
      x_div_result_o <= '0;
    end else if (x_kill_i) begin
      state        <= IDLE;
      x_div_done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (x_start_i) begin
            fun   <= x_fun_i;
            op_a  <= x_rs1_value_i;
            op_b  <= x_rs2_value_i;
            state <= PREP;
          end
        end
        PREP: begin
          if (op_b == '0) begin
            x_div_result_o <= fun[1] ? op_a : ALL_ONES;
            x_div_done_o   <= 1'b1;
            state          <= DONE;
          end else if (signed_op && op_a == MIN_NEG && op_b == ALL_ONES) begin
            x_div_result_o <= fun[1] ? '0 : MIN_NEG;
            x_div_done_o   <= 1'b1;
            state          <= DONE;
          end else begin
            dvd    <= abs_a;
            dsr    <= abs_b;
            rem    <= '0;
            cnt    <= CNT_W'(ITERS);
            sign_q <= signed_op & (op_a[XLEN-1] ^ op_b[XLEN-1]);
            sign_r <= signed_op & op_a[XLEN-1];
            state  <= ITER;
          end
        end
        ITER: begin
          dvd <= step_dvd;
          rem <= step_rem;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          x_div_result_o <= fun[1] ? fix_r : fix_q;
          x_div_done_o   <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (!x_stall_i) begin
            x_div_done_o <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_urv_div_sequencer.sv
// tb/tb_urv_div_sequencer.sv - randomized self-checking bench for urv_div_sequencer
module tb_urv_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ext_stall;
  logic        x_stall;
  logic        x_kill;
  logic        x_start;
  logic [2:0]  x_fun;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        stall_req;
  logic        div_done;
  logic [31:0] div_result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign x_stall = stall_req | ext_stall;

  urv_div_sequencer #(.XLEN(32), .STEPS_PER_CYCLE(1)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .x_stall_i      (x_stall),
    .x_kill_i       (x_kill),
    .x_start_i      (x_start),
    .x_fun_i        (x_fun),
    .x_rs1_value_i  (rs1),
    .x_rs2_value_i  (rs2),
    .x_stall_req_o  (stall_req),
    .x_div_done_o   (div_done),
    .x_div_result_o (div_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f[1] ? 32'd0 : 32'h8000_0000;
    if (!f[0]) return f[1] ? 32'(sa % sb) : 32'(sa / sb);
    return f[1] ? a % b : a / b;
  endfunction

  // Issues one divide at the current cycle and follows it to retirement.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_r;
    int          exp_lat;
    int          n;
    exp_r   = ref_result(f, a, b);
    exp_lat = is_special(f, a, b) ? 2 : 35;
    x_start = 1'b1;
    x_fun   = f;
    rs1     = a;
    rs2     = b;
    ext_stall = 1'b0;
    #1 chk("stall_at_start", 32'(stall_req), 32'd1);
    n = 0;
    while (!div_done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (!div_done) chk("stall_busy", 32'(stall_req), 32'd1);
    end
    chk("latency", n, exp_lat);
    chk("result", div_result, exp_r);
    chk("stall_in_done", 32'(stall_req), 32'd0);
    repeat (hold) begin
      ext_stall = 1'b1;
      @(posedge clk); #1;
      chk("done_held", 32'(div_done), 32'd1);
      chk("result_held", div_result, exp_r);
    end
    ext_stall = 1'b0;
    x_start   = 1'b0;
    @(posedge clk); #1;
    chk("done_cleared", 32'(div_done), 32'd0);
    chk("idle_no_stall", 32'(stall_req), 32'd0);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    rst_n = 1'b0; ext_stall = 1'b0; x_kill = 1'b0; x_start = 1'b0;
    x_fun = 3'b100; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(div_done), 32'd0);
    chk("rst_result", div_result, 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(3'b101, 32'd100, 32'd7, 0);
    do_op(3'b111, 32'd100, 32'd7, 0);
    do_op(3'b100, -32'sd7, 32'd2, 0);
    do_op(3'b110, -32'sd7, 32'd2, 0);
    do_op(3'b100, 32'h1234, 32'd0, 0);
    do_op(3'b111, 32'h1234, 32'd0, 0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 3);

    // Kill during ITER, then a fresh divide two cycles later.
    x_start = 1'b1; x_fun = 3'b101; rs1 = 32'd1000; rs2 = 32'd3;
    repeat (10) @(posedge clk);
    #1 x_kill = 1'b1;
    #1 chk("kill_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    x_kill = 1'b0; x_start = 1'b0;
    #1 chk("kill_idle", 32'(stall_req), 32'd0);
    chk("kill_no_done", 32'(div_done), 32'd0);
    @(posedge clk); #1;
    chk("kill_no_done2", 32'(div_done), 32'd0);
    do_op(3'b101, 32'd1000, 32'd3, 1);

    // Kill and start together in IDLE: nothing starts.
    x_start = 1'b1; x_kill = 1'b1;
    #1 chk("kill_start_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    x_start = 1'b0; x_kill = 1'b0;
    #1 chk("kill_start_idle", 32'(stall_req), 32'd0);
    chk("kill_start_done", 32'(div_done), 32'd0);

    // Asynchronous reset mid-operation.
    x_start = 1'b1; x_fun = 3'b100; rs1 = 32'd77; rs2 = 32'd5;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0; x_start = 1'b0;
    #1 chk("midrst_stall", 32'(stall_req), 32'd0);
    chk("midrst_done", 32'(div_done), 32'd0);
    chk("midrst_result", div_result, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", 32'(div_done), 32'd0);

    for (int i = 0; i < 40; i++) begin
      f = 3'(3'b100 | 3'($urandom_range(0, 3)));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        4: a = 32'($urandom_range(0, 50));
        default: ;
      endcase
      do_op(f, a, b, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got %h expected %h", 32'd1, 32'd0);
    $fatal(1, "timeout");
  end

endmodule
